// File: rtl/rc4_prga_engine_pkg.sv
// Shared types and helpers for the RC4 keystream engine.
package rc4_prga_engine_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StRdSi,
        StLatSi,
        StLatSj,
        StWrSi,
        StWrSj,
        StRdF,
        StWrA,
        StDone
    } state_t;

    localparam int unsigned Rc4N      = 256;
    localparam int unsigned Rc4IdxW   = $clog2(Rc4N);
    localparam logic [7:0]  SpaceChar = 8'h20;

    function automatic logic char_valid(input logic [7:0] b, input logic [7:0] lo,
                                        input logic [7:0] hi, input logic allow_space);
        return ((b >= lo) && (b <= hi)) || (allow_space && (b == SpaceChar));
    endfunction

endpackage

// File: rtl/rc4_prga_engine_if.sv
// Control handshake plus S-RAM, ciphertext ROM and plaintext RAM buses of the RC4 engine.
interface rc4_prga_engine_if #(
    parameter int unsigned MsgLogLen = 5
) ();

    logic                 start;
    logic [MsgLogLen:0]   msg_len;
    logic                 check_en;
    logic [7:0]           s_rdata;
    logic [7:0]           s_addr;
    logic [7:0]           s_wdata;
    logic                 s_wren;
    logic [7:0]           k_rdata;
    logic [MsgLogLen-1:0] k_addr;
    logic [MsgLogLen-1:0] a_addr;
    logic [7:0]           a_wdata;
    logic                 a_wren;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [MsgLogLen-1:0] fail_idx;

    modport slave (
        input  start, msg_len, check_en, s_rdata, k_rdata,
        output s_addr, s_wdata, s_wren, k_addr, a_addr, a_wdata, a_wren,
               busy, done, pass, fail_idx
    );

    modport master (
        output start, msg_len, check_en, s_rdata, k_rdata,
        input  s_addr, s_wdata, s_wren, k_addr, a_addr, a_wdata, a_wren,
               busy, done, pass, fail_idx
    );

endinterface

// File: rtl/rc4_prga_engine_trap_edge.sv
// Rising-edge detector for the level start request.
module rc4_prga_engine_trap_edge (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/rc4_prga_engine.sv
// RC4 PRGA engine: swaps S[i]/S[j], XORs keystream into ciphertext ROM bytes and writes
// plaintext RAM, with runtime length and optional abort on the first out-of-charset byte.
module rc4_prga_engine
    import rc4_prga_engine_pkg::*;
#(
    parameter int unsigned MsgLenMax  = 32,
    parameter int unsigned MsgLogLen  = 5,
    parameter logic [7:0]  CharLo     = 8'h61,
    parameter logic [7:0]  CharHi     = 8'h7A,
    parameter bit          AllowSpace = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    rc4_prga_engine_if.slave bus
);

    localparam int unsigned   LenW   = MsgLogLen + 1;
    localparam logic [LenW-1:0] LenMax = LenW'(MsgLenMax);

    state_t               state_q, state_d;
    logic [Rc4IdxW-1:0]   i_q, i_d, j_q, j_d;
    logic [7:0]           si_q, si_d, sj_q, sj_d;
    logic [MsgLogLen-1:0] k_q, k_d, fail_idx_q, fail_idx_d;
    logic [LenW-1:0]      len_q, len_d, len_clamped;
    logic                 pass_q, pass_d, chk_q, chk_d;
    logic                 start_rise;
    logic [7:0]           plain;

    rc4_prga_engine_trap_edge u_trap_edge (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .level_i  (bus.start),
        .rise_o   (start_rise)
    );

    assign len_clamped = (bus.msg_len > LenMax) ? LenMax : bus.msg_len;
    assign plain       = bus.s_rdata ^ bus.k_rdata;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            i_q        <= '0;
            j_q        <= '0;
            si_q       <= '0;
            sj_q       <= '0;
            k_q        <= '0;
            len_q      <= '0;
            pass_q     <= 1'b0;
            fail_idx_q <= '0;
            chk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            k_q        <= k_d;
            len_q      <= len_d;
            pass_q     <= pass_d;
            fail_idx_q <= fail_idx_d;
            chk_q      <= chk_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        si_d        = si_q;
        sj_d        = sj_q;
        k_d         = k_q;
        len_d       = len_q;
        pass_d      = pass_q;
        fail_idx_d  = fail_idx_q;
        chk_d       = chk_q;
        bus.s_addr  = '0;
        bus.s_wdata = '0;
        bus.s_wren  = 1'b0;
        bus.a_wdata = '0;
        bus.a_wren  = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                // check_en and length are latched so mid-run input changes are ignored
                if (start_rise) begin
                    len_d      = len_clamped;
                    i_d        = '0;
                    j_d        = '0;
                    k_d        = '0;
                    pass_d     = 1'b0;
                    fail_idx_d = '0;
                    chk_d      = bus.check_en;
                    if (len_clamped == '0) begin
                        state_d = StDone;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = StRdSi;
                    end
                end
            end
            StRdSi: begin
                i_d        = i_q + 1'b1;
                bus.s_addr = i_q + 1'b1;
                state_d    = StLatSi;
            end
            StLatSi: begin
                si_d       = bus.s_rdata;
                j_d        = j_q + bus.s_rdata;
                bus.s_addr = j_q + bus.s_rdata;
                state_d    = StLatSj;
            end
            StLatSj: begin
                sj_d    = bus.s_rdata;
                state_d = StWrSi;
            end
            StWrSi: begin
                bus.s_addr  = i_q;
                bus.s_wdata = sj_q;
                bus.s_wren  = 1'b1;
                state_d     = StWrSj;
            end
            StWrSj: begin
                bus.s_addr  = j_q;
                bus.s_wdata = si_q;
                bus.s_wren  = 1'b1;
                state_d     = StRdF;
            end
            StRdF: begin
                bus.s_addr = si_q + sj_q;
                state_d    = StWrA;
            end
            StWrA: begin
                bus.a_wdata = plain;
                if (chk_q && !char_valid(plain, CharLo, CharHi, AllowSpace)) begin
                    fail_idx_d = k_q;
                    pass_d     = 1'b0;
                    state_d    = StDone;
                end else begin
                    bus.a_wren = 1'b1;
                    if ({1'b0, k_q} == len_q - LenW'(1)) begin
                        pass_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        k_d     = k_q + MsgLogLen'(1);
                        state_d = StRdSi;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.k_addr   = k_q;
    assign bus.a_addr   = k_q;
    assign bus.busy     = (state_q != StIdle) && (state_q != StDone);
    assign bus.done     = (state_q == StDone);
    assign bus.pass     = pass_q;
    assign bus.fail_idx = fail_idx_q;

endmodule
